// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory and hands address/instr/pc+4 packets to
// the IF/ID register. It honours hazard stalls and branch redirects, and raises
// the IF/ID flush when a redirect arrives.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-low
//   stall_i        hazard stall, blocks the IF/ID load
//   redirect_i     branch/jump taken pulse
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   imem_req_o     request strobe (combinational)
//   imem_addr_o    request address (= PC register)
//   imem_rdata_i   instruction word
//   imem_rvalid_i  response valid
//   address_o      packet PC
//   instr_o        packet instruction
//   pc_add4_o      packet PC+4
//   ifid_write_o   IF/ID load enable (combinational)
//   flush_o        IF/ID flush (combinational, = redirect_i)
//   busy_o         a memory response is outstanding
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rvalid_i,
  output logic [31:0] address_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_add4_o,
  output logic        ifid_write_o,
  output logic        flush_o,
  output logic        busy_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_RESET   = RESET_PC & ALIGN_MASK;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] address_q, instr_q, pc_add4_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_pc;
  logic            pkt_load;
  logic            req_c;
  logic            write_c;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign target_pc = redirect_pc_i & ALIGN_MASK;

  // Next-state, next-PC and strobe decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pkt_load = 1'b0;
    req_c    = 1'b0;
    write_c  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          pc_d = target_pc;
        end else begin
          req_c   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = target_pc;
          // Response already here: drop it now, otherwise drain it in S_DROP.
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          pkt_load = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = target_pc;
          state_d = S_REQ;
        end else if (!stall_i) begin
          write_c = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          pc_d = target_pc;
        end
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
    endcase
  end

  // State, PC and packet registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_REQ;
      pc_q      <= PC_RESET;
      address_q <= '0;
      instr_q   <= '0;
      pc_add4_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (pkt_load) begin
        address_q <= pc_q;
        instr_q   <= imem_rdata_i;
        pc_add4_q <= pc_plus4;
      end
    end
  end

  // Strobes are suppressed while reset is held so nothing is issued or loaded.
  assign imem_req_o   = req_c & rst_i;
  assign ifid_write_o = write_c & rst_i;
  assign flush_o      = redirect_i;
  assign imem_addr_o  = pc_q;
  assign address_o    = address_q;
  assign instr_o      = instr_q;
  assign pc_add4_o    = pc_add4_q;
  assign busy_o       = (state_q == S_WAIT) || (state_q == S_DROP);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table, then randomized traffic
// against a flag-based transaction model with a randomized-latency memory.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, redirect_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, ifid_write_o, flush_o, busy_o;
  logic [31:0] imem_addr_o, address_o, instr_o, pc_add4_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_rvalid_i(imem_rvalid_i),
    .address_o(address_o), .instr_o(instr_o), .pc_add4_o(pc_add4_o),
    .ifid_write_o(ifid_write_o), .flush_o(flush_o), .busy_o(busy_o)
  );

  typedef struct {
    logic rst, st, rd; logic [31:0] rpc; logic rv; logic [31:0] rdata;
    logic chk;
    logic req; logic [31:0] iaddr; logic wr, fl, busy;
    logic [31:0] pa, pi, p4;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic st, logic rd, logic [31:0] rpc,
                              logic rv, logic [31:0] rdata, logic chk,
                              logic req, logic [31:0] iaddr, logic wr, logic fl,
                              logic busy, logic [31:0] pa, logic [31:0] pi,
                              logic [31:0] p4);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc; v.rv = rv; v.rdata = rdata;
    v.chk = chk; v.req = req; v.iaddr = iaddr; v.wr = wr; v.fl = fl;
    v.busy = busy; v.pa = pa; v.pi = pi; v.p4 = p4;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_all(input logic req, input logic [31:0] iaddr, input logic wr,
                         input logic fl, input logic busy, input logic [31:0] pa,
                         input logic [31:0] pi, input logic [31:0] p4);
    cmp("imem_req",  32'(imem_req_o),   32'(req));
    cmp("imem_addr", imem_addr_o,       iaddr);
    cmp("ifid_write",32'(ifid_write_o), 32'(wr));
    cmp("flush",     32'(flush_o),      32'(fl));
    cmp("busy",      32'(busy_o),       32'(busy));
    cmp("address",   address_o,         pa);
    cmp("instr",     instr_o,           pi);
    cmp("pc_add4",   pc_add4_o,         p4);
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural model: pending-request / discard / packet-held flags.
  logic [31:0] m_pc, m_pa, m_pi, m_p4;
  logic        m_out, m_drop, m_have, m_valid;
  // Memory: one outstanding response with random latency.
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  localparam logic [31:0] A = 32'hA000_0013, B = 32'hB000_0093;
  localparam logic [31:0] C = 32'hC000_0113, D = 32'hD000_0193, E = 32'hDEAD_BEEF;

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;

    //      rst st rd rpc           rv rdata chk req iaddr        wr fl bsy pa            pi  p4
    vt.push_back(mk(0,0,0,0,            0,0, 0, 0,0,            0,0,0, 0,0,0));
    vt.push_back(mk(0,0,0,0,            0,0, 1, 0,RST_PC,       0,0,0, 0,0,0));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,32'h100,      0,0,0, 0,0,0));
    vt.push_back(mk(1,0,0,0,            1,A, 1, 0,32'h100,      0,0,1, 0,0,0));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 0,32'h100,      1,0,0, 32'h100,A,32'h104));
    vt.push_back(mk(1,0,0,0,            1,E, 1, 1,32'h104,      0,0,0, 32'h100,A,32'h104));
    vt.push_back(mk(1,0,0,0,            1,B, 1, 0,32'h104,      0,0,1, 32'h100,A,32'h104));
    vt.push_back(mk(1,1,0,0,            0,0, 1, 0,32'h104,      0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,1,0,0,            1,E, 1, 0,32'h104,      0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,1,0,0,            0,0, 1, 0,32'h104,      0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,1,0,0,            0,0, 1, 0,32'h104,      0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 0,32'h104,      1,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,32'h108,      0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,1,32'h2001,     0,0, 1, 0,32'h108,      0,1,1, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 0,32'h2000,     0,0,1, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            1,E, 1, 0,32'h2000,     0,0,1, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,1,32'h2406,     0,0, 1, 0,32'h2000,     0,1,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,32'h2404,     0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,1,32'h3000,     1,E, 1, 0,32'h2404,     0,1,1, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,32'h3000,     0,0,0, 32'h104,B,32'h108));
    vt.push_back(mk(1,0,0,0,            1,C, 1, 0,32'h3000,     0,0,1, 32'h104,B,32'h108));
    vt.push_back(mk(1,1,1,32'hFFFF_FFFF,0,0, 1, 0,32'h3000,     0,1,0, 32'h3000,C,32'h3004));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,32'hFFFF_FFFC,0,0,0, 32'h3000,C,32'h3004));
    vt.push_back(mk(1,0,0,0,            1,D, 1, 0,32'hFFFF_FFFC,0,0,1, 32'h3000,C,32'h3004));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 0,32'hFFFF_FFFC,1,0,0, 32'hFFFF_FFFC,D,32'h0));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,32'h0,        0,0,0, 32'hFFFF_FFFC,D,32'h0));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 0,32'h0,        0,0,1, 32'hFFFF_FFFC,D,32'h0));
    vt.push_back(mk(0,0,0,0,            0,0, 1, 0,32'h0,        0,0,1, 32'hFFFF_FFFC,D,32'h0));
    vt.push_back(mk(1,0,0,0,            0,0, 1, 1,RST_PC,       0,0,0, 0,0,0));
    vt.push_back(mk(1,0,0,0,            1,A, 1, 0,RST_PC,       0,0,1, 0,0,0));

    foreach (vt[i]) begin
      @(negedge clk_i);
      rst_i = vt[i].rst; stall_i = vt[i].st; redirect_i = vt[i].rd;
      redirect_pc_i = vt[i].rpc; imem_rvalid_i = vt[i].rv; imem_rdata_i = vt[i].rdata;
      #1;
      if (vt[i].chk)
        cmp_all(vt[i].req, vt[i].iaddr, vt[i].wr, vt[i].fl, vt[i].busy,
                vt[i].pa, vt[i].pi, vt[i].p4);
    end

    // Randomized phase.
    m_valid = 1'b0; mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    m_pc = '0; m_pa = '0; m_pi = '0; m_p4 = '0; m_out = 1'b0; m_drop = 1'b0; m_have = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        s_req;
      logic [31:0] s_addr;
      @(negedge clk_i);
      rst_i         = (cyc < 2) ? 1'b0 : ($urandom_range(199) != 0);
      stall_i       = ($urandom_range(2) == 0);
      redirect_i    = ($urandom_range(9) == 0);
      redirect_pc_i = $urandom;
      if (mem_pend && mem_cnt == 0) begin
        imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(mem_addr);
      end else begin
        imem_rvalid_i = !mem_pend && ($urandom_range(7) == 0);
        imem_rdata_i  = $urandom;
      end
      #1;
      if (m_valid)
        cmp_all(rst_i && !m_out && !m_have && !redirect_i, m_pc,
                rst_i && m_have && !stall_i && !redirect_i, redirect_i, m_out,
                m_pa, m_pi, m_p4);
      s_req  = imem_req_o;
      s_addr = imem_addr_o;
      @(posedge clk_i);
      if (!rst_i) begin
        m_pc = RST_PC; m_out = 1'b0; m_drop = 1'b0; m_have = 1'b0;
        m_pa = '0; m_pi = '0; m_p4 = '0; m_valid = 1'b1; mem_pend = 1'b0;
      end else begin
        if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (s_req) begin
          mem_pend = 1'b1; mem_cnt = $urandom_range(3); mem_addr = s_addr;
        end
        if (redirect_i) begin
          m_pc   = {redirect_pc_i[31:2], 2'b00};
          m_have = 1'b0;
          if (m_out) begin
            if (imem_rvalid_i) begin m_out = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
          end
        end else if (m_out) begin
          if (imem_rvalid_i) begin
            m_out = 1'b0;
            if (!m_drop) begin
              m_have = 1'b1; m_pa = m_pc; m_pi = imem_rdata_i; m_p4 = m_pc + 32'd4;
            end
            m_drop = 1'b0;
          end
        end else if (m_have) begin
          if (!stall_i) begin m_have = 1'b0; m_pc = m_pc + 32'd4; end
        end else begin
          m_out = 1'b1; m_drop = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
